// File: rtl/simple_cnn_window_gen_if.sv
// Pixel-load and window-output signal bundle for simple_cnn_window_gen.
// The pixel source is the master, the window generator is the slave.
interface simple_cnn_window_gen_if #(
  parameter int K     = 5,
  parameter int PIX_W = 8
);
  // Handshake: a pixel transfers on a rising CLK edge where PIX_VALID and
  // PIX_READY are both 1. The window side has no back-pressure: each cycle
  // with WIN_VALID=1 carries one window (X, Y, IMGIN) that must be taken then.
  logic                   PIX_VALID;
  logic [PIX_W-1:0]       PIX_IN;
  logic                   PIX_READY;
  logic                   CNN_DONE;
  logic                   START;
  logic [4:0]             X;
  logic [4:0]             Y;
  logic [K*K*PIX_W-1:0]   IMGIN;
  logic                   WIN_VALID;
  logic                   BUSY;

  modport master (
    output PIX_VALID, PIX_IN, CNN_DONE,
    input  PIX_READY, START, X, Y, IMGIN, WIN_VALID, BUSY
  );

  modport slave (
    input  PIX_VALID, PIX_IN, CNN_DONE,
    output PIX_READY, START, X, Y, IMGIN, WIN_VALID, BUSY
  );
endinterface

// File: rtl/simple_cnn_window_gen.sv
// Buffers one square frame, then streams every KxK window (row origin outer,
// column origin inner) with no gaps, and waits for the CNN before reloading.
module simple_cnn_window_gen #(
  parameter int IMG_W = 28,
  parameter int K     = 5,
  parameter int PIX_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  simple_cnn_window_gen_if.slave bus,
  output logic [1:0]            state_dbg_o
);

  localparam int NPIX = IMG_W * IMG_W;
  localparam int AW   = $clog2(NPIX);
  localparam int WW   = K * K * PIX_W;
  localparam logic [4:0] LAST = 5'(IMG_W - K);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic [4:0]       x_q, y_q;
  logic             start_q, win_valid_q;
  logic [WW-1:0]    imgin_q;
  logic [PIX_W-1:0] mem_q [NPIX];

  logic             wr_en;
  logic             last_pix;
  logic             scan_last;
  logic [4:0]       rd_x, rd_y;
  logic [WW-1:0]    win_d;

  assign wr_en     = (state_q == LOAD) && bus.PIX_VALID && !RST;
  assign last_pix  = (cnt_q == AW'(NPIX - 1));
  assign scan_last = (x_q == LAST) && (y_q == LAST);

  // Origin of the window registered at the next edge: (0,0) while finishing
  // the load, otherwise the successor of the window currently on the outputs.
  always_comb begin
    rd_x = 5'd0;
    rd_y = 5'd0;
    if (state_q == SCAN && !scan_last) begin
      if (y_q == LAST) begin
        rd_x = x_q + 5'd1;
        rd_y = 5'd0;
      end else begin
        rd_x = x_q;
        rd_y = y_q + 5'd1;
      end
    end
  end

  // The final pixel is written on the same edge that registers window (0,0),
  // so a location being written this cycle is forwarded from PIX_IN.
  always_comb begin
    logic [AW-1:0] idx;
    win_d = '0;
    idx   = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        idx = AW'((int'(rd_x) + i) * IMG_W + int'(rd_y) + j);
        if (wr_en && idx == cnt_q) begin
          win_d[(i*K+j)*PIX_W +: PIX_W] = bus.PIX_IN;
        end else begin
          win_d[(i*K+j)*PIX_W +: PIX_W] = mem_q[idx];
        end
      end
    end
  end

  // Frame buffer is never cleared; each load rewrites every location.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[cnt_q] <= bus.PIX_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      start_q     <= 1'b0;
      win_valid_q <= 1'b0;
      imgin_q     <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.PIX_VALID) begin
            if (last_pix) begin
              cnt_q       <= '0;
              state_q     <= SCAN;
              x_q         <= 5'd0;
              y_q         <= 5'd0;
              imgin_q     <= win_d;
              win_valid_q <= 1'b1;
              start_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        SCAN: begin
          start_q <= 1'b0;
          if (scan_last) begin
            state_q     <= WAIT;
            win_valid_q <= 1'b0;
          end else begin
            x_q     <= rd_x;
            y_q     <= rd_y;
            imgin_q <= win_d;
          end
        end
        WAIT: begin
          if (bus.CNN_DONE) begin
            state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus.PIX_READY = (state_q == LOAD);
  assign bus.BUSY      = (state_q != LOAD);
  assign bus.START     = start_q;
  assign bus.X         = x_q;
  assign bus.Y         = y_q;
  assign bus.IMGIN     = imgin_q;
  assign bus.WIN_VALID = win_valid_q;
  assign state_dbg_o   = state_q;

endmodule

// File: doc/simple_cnn_window_gen.md
SIMPLE_CNN_WINDOW_GEN -- requirements
Module: simple_cnn_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning image width and height in pixels.
REQ-002 SHALL have parameter K, default 5, meaning convolution window edge.
REQ-003 SHALL have parameter PIX_W, default 8, meaning unsigned pixel width.
REQ-004 SHALL have port CLK  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port PIX_VALID  input  1  meaning PIX_IN carries a pixel.
REQ-007 SHALL have port PIX_IN  input  PIX_W  meaning raster pixel: row-major, column fastest.
REQ-008 SHALL have port PIX_READY  output  1  meaning block accepts a pixel this cycle.
REQ-009 SHALL have port CNN_DONE  input  1  meaning downstream CNN finished the frame.
REQ-010 SHALL have port START  output  1  meaning one-cycle pulse marking the first window of a frame.
REQ-011 SHALL have port X  output  5  meaning window row origin, 0..IMG_W-K.
REQ-012 SHALL have port Y  output  5  meaning window column origin, 0..IMG_W-K.
REQ-013 SHALL have port IMGIN  output  K*K*PIX_W (200)  meaning current window.
REQ-014 SHALL have port WIN_VALID  output  1  meaning X, Y, IMGIN valid this cycle.
REQ-015 SHALL have port BUSY  output  1  meaning state is not LOAD.

Function
REQ-016 SHALL hold a full IMG_W*IMG_W frame buffer of PIX_W-bit pixels.
REQ-017 SHALL implement states LOAD, SCAN, WAIT.
REQ-018 LOAD: PIX_READY=1; each cycle with PIX_VALID=1 writes PIX_IN at the pixel counter and increments it; the counter ranges 0..IMG_W*IMG_W-1.
REQ-019 LOAD -> SCAN on the cycle accepting pixel IMG_W*IMG_W-1; the counter clears to 0.
REQ-020 PIX_READY SHALL be 0 in SCAN and WAIT; PIX_VALID there SHALL be ignored, with no buffer write.
REQ-021 SCAN: WIN_VALID=1 for exactly (IMG_W-K+1)^2 = 576 consecutive cycles with no gaps.
REQ-022 Window order SHALL be X outer, Y inner: (0,0),(0,1)..(0,23),(1,0)..(23,23).
REQ-023 START SHALL be 1 only in the first SCAN cycle, at (X,Y)=(0,0); it is 0 otherwise.
REQ-024 IMGIN[(i*K+j)*PIX_W +: PIX_W] SHALL equal the pixel at row X+i, column Y+j, for i,j in 0..K-1.
REQ-025 X, Y, IMGIN, WIN_VALID and START SHALL be registered and mutually aligned in the same cycle.
REQ-026 The first START SHALL appear in the cycle after the last pixel is accepted.
REQ-027 SCAN -> WAIT after the (23,23) window cycle; WAIT: WIN_VALID=0 and START=0; X, Y, IMGIN hold their last values.
REQ-028 WAIT -> LOAD on CNN_DONE=1, with the next cycle PIX_READY=1; CNN_DONE SHALL be ignored in LOAD and SCAN.
REQ-029 Pixels SHALL be unsigned and zero-extended by nothing; no arithmetic on pixel data.
REQ-030 The frame buffer SHALL NOT be cleared between frames; every location is rewritten in LOAD.

Reset
REQ-031 RST=1 SHALL force state LOAD, pixel counter 0, X=0, Y=0, START=0, WIN_VALID=0, IMGIN=0, BUSY=0; PIX_READY=1 in the cycle after reset releases.
REQ-032 RST in any state, including mid-LOAD or mid-SCAN, SHALL discard the partial frame or scan; the next frame restarts at pixel 0.
REQ-033 RST SHALL take priority over PIX_VALID and CNN_DONE in the same cycle.

Verification
REQ-034 Load 784 pixels p(r,c)=(28r+c) mod 256 back-to-back -> START=1 the next cycle with X=0, Y=0, IMGIN[7:0]=0, IMGIN[15:8]=1, IMGIN[47:40]=28.
REQ-035 Same frame, count WIN_VALID -> exactly 576 contiguous cycles; last window X=23, Y=23, IMGIN[7:0]=155, IMGIN[199:192]=15; then WIN_VALID=0.
REQ-036 Insert random PIX_VALID gaps during LOAD -> identical window contents to REQ-034/035; START delayed only by the gaps.
REQ-037 Drive PIX_VALID=1 and CNN_DONE=1 throughout SCAN -> no buffer change, no early LOAD; after WAIT, CNN_DONE pulse -> PIX_READY=1 next cycle.
REQ-038 Assert RST at window (10,5) -> outputs at reset values; a new 784-pixel frame of all 0xAA -> every IMGIN byte 0xAA in all 576 windows.
REQ-039 Hold CNN_DONE=0 in WAIT for 100 cycles -> PIX_READY stays 0, X=23 and Y=23 held, WIN_VALID=0.
